w_col_sequencer: RTL and testbench
==================================

# w_col_sequencer

Drives the k-loop for the W-column loader (`start_k`/`col_valid`/`col_accept` handshake). For each k in 0..k_len-1 it does four things:
- issues a load;
- waits for the column;
- extracts the M words of column k from the flat tile;
- hands them to the MAC array through a one-entry valid/ready output buffer.

It sits between the MAC controller, which starts it, and the W-column loader plus the MAC column input, which it feeds. While the MAC consumes column k, the loader fetches column k+1.

## Interface
- `M`, 8, rows per column (MAC lanes)
- `KMAX`, 1024, tile depth
- `DATA_W`, 32, word width
- `K_W`, `(KMAX<=1)?1:$clog2(KMAX)`, k index width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse: begin sequence
- `k_len`  in  K_W+1  columns to process, 0..KMAX
- `busy`  out  1  level: sequence in progress
- `done`  out  1  one-cycle pulse: sequence complete
- `start_k`  out  1  pulse to loader
- `k_idx`  out  K_W  column index for loader
- `col_valid`  in  1  loader level: column loaded
- `col_accept`  out  1  pulse to loader: column taken
- `W_tile_flat`  in  M*KMAX*DATA_W  loader tile
- `col_out_valid`  out  1  output buffer full
- `col_out_ready`  in  1  MAC accepts
- `col_out_data`  out  M*DATA_W  row r at `[r*DATA_W +: DATA_W]`
- `col_out_k`  out  K_W  k of buffered column
- `col_out_last`  out  1  buffered column is k_len-1

## Operation
- **Column extraction:** row r = `W_tile_flat[((r*KMAX)+k)*DATA_W +: DATA_W]`, with k = `k_idx` of the column being captured.
- **FSM states:** IDLE, ISSUE, WAIT, DRAIN.
- **IDLE:**
  - `start` with `k_len`≠0: latch `k_len`, set `k_next`=0, go to ISSUE.
  - `start` with `k_len`=0: `done` pulses next cycle, stay in IDLE.
- **ISSUE:** `start_k`=1 for exactly this cycle, `k_idx`=`k_next`, then go to WAIT.
- **WAIT:**
  - `can_load` = !`col_out_valid` | `col_out_ready`.
  - If `col_valid` & `can_load`:
    - `col_accept`=1 (combinational, this cycle);
    - capture column into buffer, setting `col_out_data`, `col_out_k`=`k_next` and `col_out_last`=(`k_next`==`k_len`-1);
    - `col_out_valid`←1 and `k_next`++;
    - go to DRAIN if last, else ISSUE.
  - If `col_valid` & !`can_load`: hold, and `col_accept` stays 0.
- **DRAIN:** when `col_out_valid`=0, pulse `done` and go to IDLE.
- **Output buffer:** `col_out_valid` clears on `col_out_valid`&`col_out_ready` with no same-cycle capture. A capture coinciding with a drain reloads the buffer and keeps valid at 1.
- `busy` = (state≠IDLE).
- `start` while `busy`: ignored.
- `k_idx` holds `k_next` in every state.
- `k_next` never exceeds `k_len`. No wrap, because the count is `K_W+1` bits wide.

## Timing
- **Reset values:** state IDLE, `busy` 0, `done` 0, `start_k` 0, `k_idx` 0, `col_accept` 0, `col_out_valid` 0, `col_out_data` 0, `col_out_k` 0, `col_out_last` 0.
- **Start:** `start` sampled at edge n puts `start_k` high during cycle n+1.
- **Capture to next load:** capture at edge c puts the next `start_k` in cycle c+1. The loader is back in IDLE by then, because `col_accept` was seen at edge c.
- **Output data timing:** `col_out_*` is registered and valid the cycle after capture.
- **Done timing:** `done` is asserted in the first DRAIN cycle with `col_out_valid`=0. Same for IDLE for the `k_len`=0 case.
- **Output stability:** data stays stable while `col_out_valid` & !`col_out_ready`.
- **Reset mid-sequence:** return to reset values next edge. No `col_accept` is issued. Loader state is not touched.
- **Throughput:** per column = loader latency + 2 cycles, when `col_out_ready` is held high.

## Structure
- Package `w_col_pkg`: `st_t` enum {IDLE, ISSUE, WAIT, DRAIN}, plus `w_idx(row,k)` offset function shared with the loader.
- Sub-module `w_col_extract`: combinational M-way word select of column k from `W_tile_flat`.

## Test plan
Tests use M=4, KMAX=8 and a behavioural loader with 1-cycle SRAM; tile word = {row,k}.
1. `k_len`=3, `col_out_ready`=1 → 3 columns with `col_out_k` 0,1,2, `col_out_data` row r = {r,k}, `col_out_last` only on k=2, one `done` pulse after the last drain, 3 `start_k` pulses.
2. `k_len`=0 → no `start_k`, `done` one cycle after `start`, `busy` stays 0.
3. `col_out_ready`=0 for 20 cycles during `k_len`=2 → column 1 held in loader (`col_accept`=0) and buffer k=0 stable; release gives in-order delivery with no loss.
4. `col_out_ready` asserted in the same cycle `col_valid` arrives → capture and drain coincide, `col_out_valid` stays 1, and the k increments.
5. `rst` during WAIT of `k_len`=5 → all outputs reset next cycle; a new `start` with `k_len`=1 completes normally.
6. `start` pulsed while `busy` → ignored, sequence count unchanged.

Source files
------------

// File: rtl/w_col_pkg.sv
// Shared types and tile addressing for the W-column path.
// The word-offset helper is also used by the loader, so both sides agree on tile layout.
package w_col_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } st_t;

  // Word offset of (row, k) inside a row-major M x KMAX tile.
  function automatic int w_idx(input int row, input int k, input int kmax);
    return (row * kmax) + k;
  endfunction

endpackage

// File: rtl/w_col_extract.sv
// Combinational M-way select of column k from the flat W tile.
module w_col_extract
  import w_col_pkg::*;
#(
  parameter int M      = 8,
  parameter int KMAX   = 1024,
  parameter int DATA_W = 32,
  parameter int K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
  input  logic [M*KMAX*DATA_W-1:0] tile_i,
  input  logic [K_W-1:0]           k_i,
  output logic [M*DATA_W-1:0]      col_o
);

  // Gather one word per row at column k_i.
  always_comb begin
    col_o = '0;
    for (int r = 0; r < M; r++) begin
      col_o[r*DATA_W +: DATA_W] = tile_i[w_idx(r, int'(k_i), KMAX)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/w_col_sequencer.sv
// Walks k over 0..k_len-1: issues a load, waits for the column, extracts it and
// hands it to the MAC through a one-entry valid/ready buffer, overlapping the next load.
module w_col_sequencer
  import w_col_pkg::*;
#(
  parameter int M      = 8,
  parameter int KMAX   = 1024,
  parameter int DATA_W = 32,
  parameter int K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [K_W:0]             k_len,
  output logic                     busy,
  output logic                     done,
  output logic                     start_k,
  output logic [K_W-1:0]           k_idx,
  input  logic                     col_valid,
  output logic                     col_accept,
  input  logic [M*KMAX*DATA_W-1:0] W_tile_flat,
  output logic                     col_out_valid,
  input  logic                     col_out_ready,
  output logic [M*DATA_W-1:0]      col_out_data,
  output logic [K_W-1:0]           col_out_k,
  output logic                     col_out_last
);

  st_t                 state_q, state_d;
  logic [K_W:0]        k_len_q, k_len_d;
  logic [K_W:0]        k_next_q, k_next_d;
  logic                done_q, done_d;
  logic                drain_done_s;
  logic                capture_s;
  logic                can_load_s;
  logic                last_s;
  logic [M*DATA_W-1:0] col_s;
  logic                out_valid_q;
  logic [M*DATA_W-1:0] out_data_q;
  logic [K_W-1:0]      out_k_q;
  logic                out_last_q;

  w_col_extract #(
    .M      (M),
    .KMAX   (KMAX),
    .DATA_W (DATA_W),
    .K_W    (K_W)
  ) u_extract (
    .tile_i (W_tile_flat),
    .k_i    (k_next_q[K_W-1:0]),
    .col_o  (col_s)
  );

  assign can_load_s = !out_valid_q || col_out_ready;
  assign last_s     = (k_next_q == (k_len_q - {{K_W{1'b0}}, 1'b1}));

  // Next-state and handshake decode.
  always_comb begin
    state_d      = state_q;
    k_len_d      = k_len_q;
    k_next_d     = k_next_q;
    done_d       = 1'b0;
    drain_done_s = 1'b0;
    capture_s    = 1'b0;
    start_k      = 1'b0;
    col_accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (k_len != {(K_W+1){1'b0}}) begin
            k_len_d  = k_len;
            k_next_d = {(K_W+1){1'b0}};
            state_d  = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        start_k = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A ready column stays with the loader until the buffer can take it.
        if (col_valid && can_load_s) begin
          col_accept = 1'b1;
          capture_s  = 1'b1;
          k_next_d   = k_next_q + {{K_W{1'b0}}, 1'b1};
          state_d    = last_s ? DRAIN : ISSUE;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        if (!out_valid_q) begin
          drain_done_s = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_len_q  <= {(K_W+1){1'b0}};
      k_next_q <= {(K_W+1){1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_len_q  <= k_len_d;
      k_next_q <= k_next_d;
      done_q   <= done_d;
    end
  end

  // One-entry output buffer; a capture wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_k_q     <= {K_W{1'b0}};
      out_last_q  <= 1'b0;
    end else if (capture_s) begin
      out_valid_q <= 1'b1;
      out_data_q  <= col_s;
      out_k_q     <= k_next_q[K_W-1:0];
      out_last_q  <= last_s;
    end else if (out_valid_q && col_out_ready) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q || drain_done_s;
  assign k_idx         = k_next_q[K_W-1:0];
  assign col_out_valid = out_valid_q;
  assign col_out_data  = out_data_q;
  assign col_out_k     = out_k_q;
  assign col_out_last  = out_last_q;

endmodule

// File: tb/tb_w_col_sequencer.sv
// Scoreboard bench for w_col_sequencer with a behavioural loader of random latency.
module tb_w_col_sequencer;

  localparam int M      = 4;
  localparam int KMAX   = 8;
  localparam int DATA_W = 32;
  localparam int K_W    = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [K_W:0]             k_len;
  logic                     busy, done, start_k, col_accept;
  logic [K_W-1:0]           k_idx;
  logic                     col_valid;
  logic [M*KMAX*DATA_W-1:0] W_tile_flat;
  logic                     col_out_valid, col_out_ready, col_out_last;
  logic [M*DATA_W-1:0]      col_out_data;
  logic [K_W-1:0]           col_out_k;

  logic rdy_fix, rdy_rand, rnd_bit;
  assign col_out_ready = rdy_rand ? rnd_bit : rdy_fix;

  w_col_sequencer #(.M(M), .KMAX(KMAX), .DATA_W(DATA_W), .K_W(K_W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .start_k(start_k), .k_idx(k_idx), .col_valid(col_valid), .col_accept(col_accept),
    .W_tile_flat(W_tile_flat), .col_out_valid(col_out_valid), .col_out_ready(col_out_ready),
    .col_out_data(col_out_data), .col_out_k(col_out_k), .col_out_last(col_out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  k;
    logic [M*DATA_W-1:0] data;
    logic                last;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   start_cnt = 0;
  int   done_cnt = 0;

  function automatic logic [M*DATA_W-1:0] exp_col(input int k);
    logic [M*DATA_W-1:0] d;
    d = '0;
    for (int r = 0; r < M; r++) d[r*DATA_W +: DATA_W] = {16'(r), 16'(k)};
    return d;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timeout got busy=%0b expected idle", name, busy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int n);
    for (int k = 0; k < n; k++) sb.push_back('{k, exp_col(k), (k == n - 1)});
  endtask

  task automatic start_seq(input int n);
    k_len = (K_W+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    while ((busy || sb.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) timeout(name);
  endtask

  task automatic wait_held(input string name);
    int c;
    c = 0;
    while (!(col_out_valid && col_valid) && c < 60) begin
      tick();
      c++;
    end
    if (c >= 60) timeout(name);
  endtask

  // Loader: after start_k, raise col_valid after 0..2 extra cycles; drop on col_accept.
  logic pend;
  int   lat_cnt;
  always @(posedge clk) begin
    if (rst) begin
      col_valid <= 1'b0;
      pend      <= 1'b0;
      lat_cnt   <= 0;
    end else begin
      if (col_accept) col_valid <= 1'b0;
      if (start_k) begin
        pend    <= 1'b1;
        lat_cnt <= int'($urandom_range(0, 2));
      end else if (pend) begin
        if (lat_cnt == 0) begin
          col_valid <= 1'b1;
          pend      <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: pop the scoreboard on every output transfer, count pulses.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (start_k) start_cnt++;
      if (done) done_cnt++;
      if (col_out_valid && col_out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_col: got k=%0d expected no column", col_out_k);
        end else begin
          e = sb.pop_front();
          check("col_k", 128'(col_out_k), 128'(e.k));
          check("col_data", col_out_data, e.data);
          check("col_last", 128'(col_out_last), 128'(e.last));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int s0, d0, bad, n;
    for (int r = 0; r < M; r++)
      for (int k = 0; k < KMAX; k++)
        W_tile_flat[((r*KMAX)+k)*DATA_W +: DATA_W] = {16'(r), 16'(k)};
    rst = 1'b1; start = 1'b0; k_len = '0; rdy_fix = 1'b1; rdy_rand = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_ctrl", 128'({busy, done, start_k, k_idx, col_accept, col_out_valid, col_out_k, col_out_last}), 128'(0));
    check("reset_data", col_out_data, 128'(0));
    tick();
    rst = 1'b0;
    tick();

    // 1: three columns, ready high
    s0 = start_cnt; d0 = done_cnt;
    push_seq(3);
    start_seq(3);
    @(negedge clk);
    check("t1_busy", 128'(busy), 128'(1));
    wait_idle(200, "t1");
    tick();
    check("t1_starts", 128'(start_cnt - s0), 128'(3));
    check("t1_done", 128'(done_cnt - d0), 128'(1));

    // 2: k_len = 0
    s0 = start_cnt; d0 = done_cnt;
    start_seq(0);
    @(negedge clk);
    check("t2_done_pulse", 128'(done), 128'(1));
    check("t2_busy", 128'(busy), 128'(0));
    repeat (4) tick();
    check("t2_busy_later", 128'(busy), 128'(0));
    check("t2_starts", 128'(start_cnt - s0), 128'(0));
    check("t2_done", 128'(done_cnt - d0), 128'(1));

    // 3: backpressure for 20 cycles
    s0 = start_cnt; d0 = done_cnt; rdy_fix = 1'b0;
    push_seq(2);
    start_seq(2);
    wait_held("t3_held");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!col_out_valid || col_out_k != 3'd0 || col_out_data != exp_col(0) || col_accept) bad++;
      tick();
    end
    check("t3_hold", 128'(bad), 128'(0));
    rdy_fix = 1'b1;
    wait_idle(200, "t3");
    tick();
    check("t3_done", 128'(done_cnt - d0), 128'(1));

    // 4: ready rises in the cycle the next column is waiting
    rdy_fix = 1'b0;
    push_seq(2);
    start_seq(2);
    wait_held("t4_held");
    rdy_fix = 1'b1;
    @(negedge clk);
    check("t4_accept", 128'(col_accept), 128'(1));
    tick();
    check("t4_valid", 128'(col_out_valid), 128'(1));
    check("t4_k", 128'(col_out_k), 128'(1));
    check("t4_kidx", 128'(k_idx), 128'(2));
    wait_idle(200, "t4");

    // 5: reset in WAIT, then a fresh single-column run
    s0 = start_cnt;
    push_seq(5);
    start_seq(5);
    n = 0;
    while (start_cnt - s0 < 2 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("t5_reach");
    rst = 1'b1;
    sb.delete();
    tick();
    @(negedge clk);
    check("t5_rst_ctrl", 128'({busy, done, start_k, k_idx, col_accept, col_out_valid, col_out_k, col_out_last}), 128'(0));
    check("t5_rst_data", col_out_data, 128'(0));
    tick();
    rst = 1'b0;
    s0 = start_cnt; d0 = done_cnt;
    push_seq(1);
    start_seq(1);
    wait_idle(200, "t5");
    tick();
    check("t5_starts", 128'(start_cnt - s0), 128'(1));
    check("t5_done", 128'(done_cnt - d0), 128'(1));

    // 6: start while busy is ignored
    s0 = start_cnt; d0 = done_cnt;
    push_seq(3);
    start_seq(3);
    tick();
    start_seq(5);
    wait_idle(200, "t6");
    repeat (3) tick();
    check("t6_starts", 128'(start_cnt - s0), 128'(3));
    check("t6_done", 128'(done_cnt - d0), 128'(1));

    // 7: random lengths with random ready
    s0 = start_cnt; d0 = done_cnt; rdy_rand = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(1, KMAX));
      bad += n;
      push_seq(n);
      start_seq(n);
      wait_idle(600, "t7");
      tick();
    end
    rdy_rand = 1'b0;
    check("t7_starts", 128'(start_cnt - s0), 128'(bad));
    check("t7_done", 128'(done_cnt - d0), 128'(6));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
